mpmc10_resv_mgr: RTL and testbench

- Owns the address-reservation table (load-reserved / store-conditional) for the mpmc10 multi-port memory controller.
- Records a reservation when a channel issues a load-reserved. Kills reservations on stores to the reserved 32-byte line, on the owning channel's conditional store, or on timeout.
- Drives the resv_ch/resv_adr arrays that the per-port reservation-status logic compares against conditional stores. It is the writer of the table that logic reads.

---
 rtl/mpmc10_resv_mgr.sv | 165 ++++++++++++++++
 tb/tb_mpmc10_resv_mgr.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mpmc10_resv_mgr.sv
// mpmc10_pkg: controller-wide constants shared with the reservation manager.
//
// mpmc10_resv_entry: one reservation slot (valid, owner channel, address, age).
//   Ports: clk, rst_n; kill_i (invalidate, highest priority), load_i
//   (allocate/refresh with ch_i/adr_i); v_o/ch_o/adr_o expose the slot.
//
// mpmc10_resv_mgr: load-reserved / store-conditional reservation table.
//   Ports: clk, rst_n (async, active low); state/req/ch/we/cr/rsv/adr command
//   inputs; ack pulses the cycle after an accepted command; resv_ch/resv_adr/
//   resv_v publish the table to the per-port reservation-status logic.
package mpmc10_pkg;
  localparam int NAR = 2;
  typedef logic [3:0] mpmc10_state_t;
  localparam mpmc10_state_t IDLE = 4'd0;
endpackage

module mpmc10_resv_entry #(
  parameter int         TIMEOUT = 1024,
  parameter logic [3:0] INV_CH  = 4'hF,
  parameter int         AW      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kill_i,
  input  logic        load_i,
  input  logic [3:0]  ch_i,
  input  logic [31:0] adr_i,
  output logic        v_o,
  output logic [3:0]  ch_o,
  output logic [31:0] adr_o
);
  logic          v_q, v_d;
  logic [3:0]    ch_q, ch_d;
  logic [31:0]   adr_q, adr_d;
  logic [AW-1:0] age_q, age_d;
  logic          tmo;

  always_comb begin
    // Entry expires on the edge where its age reaches TIMEOUT-1, giving
    // exactly TIMEOUT valid cycles after the allocating edge.
    tmo   = (TIMEOUT > 0) && v_q && (age_q == AW'(TIMEOUT - 1));
    v_d   = v_q;
    ch_d  = ch_q;
    adr_d = adr_q;
    age_d = ((TIMEOUT > 0) && v_q) ? age_q + 1'b1 : age_q;
    // Store-kill beats refresh; refresh beats timeout. Address is held on kill.
    if (kill_i || (tmo && !load_i)) begin
      v_d   = 1'b0;
      ch_d  = INV_CH;
      age_d = '0;
    end else if (load_i) begin
      v_d   = 1'b1;
      ch_d  = ch_i;
      adr_d = adr_i;
      age_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      ch_q  <= INV_CH;
      adr_q <= '0;
      age_q <= '0;
    end else begin
      v_q   <= v_d;
      ch_q  <= ch_d;
      adr_q <= adr_d;
      age_q <= age_d;
    end
  end

  assign v_o   = v_q;
  assign ch_o  = ch_q;
  assign adr_o = adr_q;
endmodule

module mpmc10_resv_mgr #(
  parameter int         NAR     = mpmc10_pkg::NAR,
  parameter int         TIMEOUT = 1024,
  parameter logic [3:0] INV_CH  = 4'hF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  mpmc10_pkg::mpmc10_state_t state,
  input  logic                      req,
  input  logic [3:0]                ch,
  input  logic                      we,
  input  logic                      cr,
  input  logic                      rsv,
  input  logic [31:0]               adr,
  output logic                      ack,
  output logic [3:0]                resv_ch  [0:NAR-1],
  output logic [31:0]               resv_adr [0:NAR-1],
  output logic [NAR-1:0]            resv_v
);
  localparam int AW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int VW = (NAR > 1) ? $clog2(NAR) : 1;

  logic          ack_q, ack_d;
  logic [VW-1:0] victim_q, victim_d;
  logic          acc, lr, any_own, any_free;
  logic [VW-1:0] free_idx;
  logic [NAR-1:0] own_hit, kill, load;

  always_comb begin
    acc = req && (state == mpmc10_pkg::IDLE);
    lr  = acc && !we && rsv;
    // Lowest-index invalid entry; entries expiring this cycle still count as valid.
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NAR - 1; i >= 0; i--) begin
      if (!resv_v[i]) begin
        free_idx = VW'(i);
        any_free = 1'b1;
      end
    end
    for (int i = 0; i < NAR; i++) begin
      own_hit[i] = resv_v[i] && (resv_ch[i] == ch);
      kill[i]    = acc && we && resv_v[i] &&
                   ((resv_adr[i][31:5] == adr[31:5]) || (cr && own_hit[i]));
    end
    any_own = |own_hit;
    for (int i = 0; i < NAR; i++) begin
      load[i] = lr && (any_own  ? own_hit[i] :
                       any_free ? (free_idx == VW'(i)) :
                                  (victim_q == VW'(i)));
    end
    // Victim only moves when a full table forces a replacement.
    victim_d = victim_q;
    if (lr && !any_own && !any_free)
      victim_d = (victim_q == VW'(NAR - 1)) ? '0 : victim_q + 1'b1;
    ack_d = acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      victim_q <= '0;
    end else begin
      ack_q    <= ack_d;
      victim_q <= victim_d;
    end
  end

  assign ack = ack_q;

  for (genvar g = 0; g < NAR; g++) begin : g_ent
    mpmc10_resv_entry #(
      .TIMEOUT(TIMEOUT),
      .INV_CH (INV_CH),
      .AW     (AW)
    ) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .kill_i(kill[g]),
      .load_i(load[g]),
      .ch_i  (ch),
      .adr_i (adr),
      .v_o   (resv_v[g]),
      .ch_o  (resv_ch[g]),
      .adr_o (resv_adr[g])
    );
  end
endmodule

// File: tb/tb_mpmc10_resv_mgr.sv
// Randomized + directed bench for mpmc10_resv_mgr against a lifetime-countdown
// reference model of the reservation table.
module tb_mpmc10_resv_mgr;
  localparam int         NAR = 2;
  localparam int         TMO = 16;
  localparam logic [3:0] INV = 4'hF;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req = 1'b0, we = 1'b0, cr = 1'b0, rsv = 1'b0;
  logic [3:0]  ch  = '0;
  logic [31:0] adr = '0;
  mpmc10_pkg::mpmc10_state_t state = mpmc10_pkg::IDLE;
  logic ack;
  logic [3:0]  resv_ch  [0:NAR-1];
  logic [31:0] resv_adr [0:NAR-1];
  logic [NAR-1:0] resv_v;

  mpmc10_resv_mgr #(.NAR(NAR), .TIMEOUT(TMO), .INV_CH(INV)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .req(req), .ch(ch), .we(we),
    .cr(cr), .rsv(rsv), .adr(adr), .ack(ack), .resv_ch(resv_ch),
    .resv_adr(resv_adr), .resv_v(resv_v));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Model: each live reservation carries its remaining lifetime in cycles.
  bit          m_v    [NAR];
  logic [3:0]  m_ch   [NAR];
  logic [31:0] m_adr  [NAR];
  int          m_life [NAR];
  int          m_vic;
  bit          m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NAR; i++) begin
      m_v[i] = 0; m_ch[i] = INV; m_adr[i] = '0; m_life[i] = 0;
    end
    m_vic = 0; m_ack = 0;
  endtask

  task automatic model_step();
    bit acc;
    int t;
    bit          nv [NAR];
    logic [3:0]  nch[NAR];
    logic [31:0] nadr[NAR];
    int          nlife[NAR];
    acc = req && (state == mpmc10_pkg::IDLE);
    for (int i = 0; i < NAR; i++) begin
      nv[i] = m_v[i]; nch[i] = m_ch[i]; nadr[i] = m_adr[i]; nlife[i] = m_life[i];
      if (m_v[i]) begin
        nlife[i] = m_life[i] - 1;
        if (nlife[i] == 0) begin nv[i] = 0; nch[i] = INV; end
      end
    end
    if (acc && we) begin
      for (int i = 0; i < NAR; i++)
        if (m_v[i] && ((m_adr[i] >> 5) == (adr >> 5) || (cr && m_ch[i] == ch))) begin
          nv[i] = 0; nch[i] = INV; nlife[i] = 0;
        end
    end
    if (acc && !we && rsv) begin
      t = -1;
      for (int i = 0; i < NAR; i++) if (t < 0 && m_v[i] && m_ch[i] == ch) t = i;
      for (int i = 0; i < NAR; i++) if (t < 0 && !m_v[i]) t = i;
      if (t < 0) begin t = m_vic; m_vic = (m_vic + 1) % NAR; end
      nv[t] = 1; nch[t] = ch; nadr[t] = adr; nlife[t] = TMO;
    end
    for (int i = 0; i < NAR; i++) begin
      m_v[i] = nv[i]; m_ch[i] = nch[i]; m_adr[i] = nadr[i]; m_life[i] = nlife[i];
    end
    m_ack = acc;
  endtask

  task automatic check_all();
    chk("ack", {31'd0, ack}, {31'd0, m_ack});
    for (int i = 0; i < NAR; i++) begin
      chk($sformatf("v%0d", i), {31'd0, resv_v[i]}, {31'd0, m_v[i]});
      chk($sformatf("ch%0d", i), {28'd0, resv_ch[i]}, {28'd0, m_ch[i]});
      chk($sformatf("adr%0d", i), resv_adr[i], m_adr[i]);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cyc(input bit r, input logic [3:0] c, input bit w, input bit q,
                     input bit s, input logic [31:0] a, input mpmc10_pkg::mpmc10_state_t st);
    req = r; ch = c; we = w; cr = q; rsv = s; adr = a; state = st;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 4'd0, 0, 0, 0, 32'd0, mpmc10_pkg::IDLE);
  endtask

  task automatic lr(input logic [3:0] c, input logic [31:0] a);
    cyc(1, c, 0, 0, 1, a, mpmc10_pkg::IDLE);
  endtask

  task automatic st(input logic [3:0] c, input bit q, input logic [31:0] a);
    cyc(1, c, 1, q, 0, a, mpmc10_pkg::IDLE);
  endtask

  // Asynchronous reset asserted between edges; outputs checked before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // First load-reserved lands in entry 0.
    lr(4'd1, 32'h0000_1040);
    chk("tp1_ack", {31'd0, ack}, 32'd1);
    chk("tp1_v", {30'd0, resv_v}, 32'd1);
    chk("tp1_ch0", {28'd0, resv_ch[0]}, 32'd1);
    chk("tp1_adr0", resv_adr[0], 32'h0000_1040);
    chk("tp1_ch1", {28'd0, resv_ch[1]}, 32'hF);
    idle(1);
    chk("tp1_ack_gone", {31'd0, ack}, 32'd0);

    // Overflow replacement walks the victim pointer.
    do_reset();
    lr(4'd1, 32'h1040); lr(4'd2, 32'h2000); lr(4'd3, 32'h3000);
    chk("ovf_ch0", {28'd0, resv_ch[0]}, 32'd3);
    chk("ovf_ch1", {28'd0, resv_ch[1]}, 32'd2);
    lr(4'd4, 32'h4000);
    chk("ovf2_ch1", {28'd0, resv_ch[1]}, 32'd4);
    chk("ovf2_ch0", {28'd0, resv_ch[0]}, 32'd3);

    // Store to the reserved line kills; store to the next line does not.
    do_reset();
    lr(4'd1, 32'h1040);
    st(4'd5, 0, 32'h1060);
    chk("st_other_v", {30'd0, resv_v}, 32'd1);
    st(4'd5, 0, 32'h105C);
    chk("st_line_v", {30'd0, resv_v}, 32'd0);
    chk("st_line_ch0", {28'd0, resv_ch[0]}, 32'hF);
    chk("st_line_adr0", resv_adr[0], 32'h1040);

    // Conditional store kills only the owner's entry.
    do_reset();
    lr(4'd1, 32'h1040);
    st(4'd2, 1, 32'h9000);
    chk("sc_other_v", {30'd0, resv_v}, 32'd1);
    st(4'd1, 1, 32'h9000);
    chk("sc_own_v", {30'd0, resv_v}, 32'd0);

    // Timeout: valid for exactly TMO cycles after allocation.
    do_reset();
    lr(4'd1, 32'h1040);
    idle(TMO - 1);
    chk("tmo_last_v", {31'd0, resv_v[0]}, 32'd1);
    idle(1);
    chk("tmo_exp_v", {31'd0, resv_v[0]}, 32'd0);
    // Refresh at cycle 10 extends the lifetime.
    lr(4'd1, 32'h1040);
    idle(9);
    lr(4'd1, 32'h1080);
    idle(TMO - 1);
    chk("rfs_last_v", {31'd0, resv_v[0]}, 32'd1);
    idle(1);
    chk("rfs_exp_v", {31'd0, resv_v[0]}, 32'd0);

    // Commands outside IDLE are ignored; reset mid-table drops a pending ack.
    do_reset();
    cyc(1, 4'd1, 0, 0, 1, 32'h1040, 4'd3);
    chk("busy_ack", {31'd0, ack}, 32'd0);
    chk("busy_v", {30'd0, resv_v}, 32'd0);
    lr(4'd1, 32'h1040); lr(4'd2, 32'h2000);
    do_reset();
    chk("rst_v", {30'd0, resv_v}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);

    // Random traffic over a few lines and channels.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(199) == 0) do_reset();
      else cyc($urandom_range(3) != 0, 4'($urandom_range(5)), $urandom_range(2) == 0,
               $urandom_range(1) == 1, $urandom_range(2) != 0,
               (32'($urandom_range(3)) << 5) | 32'($urandom_range(31)) | 32'h1000,
               ($urandom_range(4) == 0) ? 4'($urandom_range(15, 1)) : mpmc10_pkg::IDLE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
